// File: rtl/rr_arbiter_if.sv
// Requester-side bus of the round-robin arbiter: request vector and done
// strobe in, registered grant index / one-hot / valid / timeout out.
interface rr_arbiter_if #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
);
  logic [N-1:0]    req;
  logic            done;
  logic [IDXW-1:0] grant;
  logic [N-1:0]    gnt_onehot;
  logic            valid;
  logic            timeout;

  // Requesters / datapath side.
  modport master (
    output req, done,
    input  grant, gnt_onehot, valid, timeout
  );

  // Arbiter side.
  modport slave (
    input  req, done,
    output grant, gnt_onehot, valid, timeout
  );
endinterface

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter with grant holding.
// An idle arbiter grants the first active request at or after a rotating
// pointer. The grant is held until the owner signals done or drops its
// request. On release, priority rotates past the owner and the next winner
// is granted in the same edge, so there is no bubble.
// Optional feature: define RR_ARB_TIMEOUT_EN to force-release an owner
// after MAX_HOLD cycles and pulse timeout for that cycle.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int IDXW     = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter_if.slave  bus
);

  // Reject out-of-range configurations at elaboration time.
  if (N < 2 || N > 16) begin : g_bad_n
    $error("rr_arbiter: N must be in 2..16");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_arbiter: MAX_HOLD must be in 1..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] grant_q, grant_d;
  logic [N-1:0]    onehot_q, onehot_d;
  logic            release_w;
  logic            force_rel_w;
  logic [IDXW:0]   win_w;

  // Returns {found, index} of the first set request scanning from p
  // upward and wrapping at N (not at 2**IDXW).
  function automatic logic [IDXW:0] pick(input logic [N-1:0]    r,
                                         input logic [IDXW-1:0] p);
    logic [IDXW:0] res;
    res = '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = int'(p) + i;
      if (k >= N) k = k - N;
      if (r[k] && !res[IDXW]) res = {1'b1, IDXW'(k)};
    end
    return res;
  endfunction

  // Next-state logic: new grants, release, rotation and reselection.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    release_w = 1'b0;
    win_w     = '0;
    onehot_d  = '0;

    case (state_q)
      IDLE: begin
        win_w = pick(bus.req, ptr_q);
        if (win_w[IDXW]) begin
          state_d = OWNED;
          grant_d = win_w[IDXW-1:0];
        end
      end
      OWNED: begin
        // done, dropped request and timeout merge into one release event.
        release_w = bus.done || !bus.req[grant_q] || force_rel_w;
        if (release_w) begin
          ptr_d = (grant_q == IDXW'(N - 1)) ? '0 : grant_q + 1'b1;
          win_w = pick(bus.req, ptr_d);
          if (win_w[IDXW]) begin
            grant_d = win_w[IDXW-1:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == OWNED) onehot_d[grant_d] = 1'b1;
  end

  // State and output registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      onehot_q <= onehot_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.gnt_onehot = onehot_q;
  assign bus.valid      = (state_q == OWNED);

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q;

  // Forced release only when no natural release cause is present.
  always_comb begin
    force_rel_w = (state_q == OWNED) && (hold_q == 8'(MAX_HOLD - 1)) &&
                  bus.req[grant_q] && !bus.done;
    hold_d      = (state_q == OWNED && !release_w) ? hold_q + 8'd1 : 8'd0;
  end

  // Hold counter and one-cycle timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= force_rel_w;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign force_rel_w = 1'b0;
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=4, MAX_HOLD=4). Inputs change #1 after
// the rising edge; registered outputs are compared at that same point.
module tb_rr_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  rr_arbiter_if #(.N(N)) bus ();

  rr_arbiter #(.N(N), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check {timeout, valid, gnt_onehot, grant} in one comparison.
  task automatic check_out(input string tag, input logic to, input logic v,
                           input logic [N-1:0] oh, input logic [1:0] g);
    check(tag, {bus.timeout, bus.valid, bus.gnt_onehot, bus.grant},
          {to, v, oh, g});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;

    // Reset / idle.
    tick(); tick();
    check_out("reset", 0, 0, 4'b0000, 2'd0);
    rst = 1'b0;
    tick();
    check_out("idle_no_req", 0, 0, 4'b0000, 2'd0);

    // Single requester; re-granted as sole requester, ptr moves to 3.
    bus.req = 4'b0100;
    tick();
    check_out("single_grant", 0, 1, 4'b0100, 2'd2);
    bus.done = 1'b1;
    tick();
    check_out("single_regrant", 0, 1, 4'b0100, 2'd2);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    tick();
    check_out("drop_to_idle", 0, 0, 4'b0000, 2'd2);
    bus.req = 4'b1111;
    tick();
    check_out("ptr_was_3", 0, 1, 4'b1000, 2'd3);
    bus.done = 1'b1;
    tick();
    check_out("wrap_after_3", 0, 1, 4'b0001, 2'd0);
    bus.done = 1'b0;

    // Rotation fairness: done held high from reset.
    bus.req  = 4'b1111;
    bus.done = 1'b1;
    do_reset();
    tick();
    check_out("rot_0", 0, 1, 4'b0001, 2'd0);
    tick();
    check_out("rot_1", 0, 1, 4'b0010, 2'd1);
    tick();
    check_out("rot_2", 0, 1, 4'b0100, 2'd2);
    tick();
    check_out("rot_3", 0, 1, 4'b1000, 2'd3);
    tick();
    check_out("rot_0_again", 0, 1, 4'b0001, 2'd0);
    bus.done = 1'b0;

    // Hold and wrap.
    bus.req = 4'b1010;
    do_reset();
    tick();
    check_out("hold_grant1", 0, 1, 4'b0010, 2'd1);
    bus.req = 4'b1011;
    tick();
    check_out("hold_ignore_a", 0, 1, 4'b0010, 2'd1);
    tick();
    check_out("hold_ignore_b", 0, 1, 4'b0010, 2'd1);
    bus.req = 4'b1001;
    tick();
    check_out("drop_to_3", 0, 1, 4'b1000, 2'd3);
    bus.req  = 4'b0001;
    bus.done = 1'b1;
    tick();
    check_out("wrap_to_0", 0, 1, 4'b0001, 2'd0);
    bus.done = 1'b0;
    tick();
    check_out("hold_0", 0, 1, 4'b0001, 2'd0);

    // Done together with req drop is a single release: 0 released, ptr=1.
    bus.req  = 4'b0110;
    bus.done = 1'b1;
    tick();
    check_out("done_and_drop", 0, 1, 4'b0010, 2'd1);
    bus.done = 1'b0;

    // Reset mid-grant.
    bus.req = 4'b0100;
    do_reset();
    tick();
    check_out("pre_mid_reset", 0, 1, 4'b0100, 2'd2);
    rst = 1'b1;
    tick();
    check_out("mid_reset", 0, 0, 4'b0000, 2'd0);
    rst     = 1'b0;
    bus.req = 4'b1111;
    tick();
    check_out("after_reset_ptr0", 0, 1, 4'b0001, 2'd0);

    // Timeout behaviour.
    bus.req = 4'b0011;
    do_reset();
`ifdef RR_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("to_hold_%0d", i), 0, 1, 4'b0001, 2'd0);
    end
    tick();
    check_out("to_pulse", 1, 1, 4'b0010, 2'd1);
    tick();
    check_out("to_after", 0, 1, 4'b0010, 2'd1);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      check_out($sformatf("no_to_hold_%0d", i), 0, 1, 4'b0001, 2'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
